// File: rtl/fifo_modport.sv
// Single-clock 32x32 synchronous FIFO exposing the write-side signal set plus a
// minimal read port; storage has its own synchronous clear independent of hw_rst.
module fifo_modport #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic                       wclk,
    input  logic                       hw_rst,
    input  logic                       mem_rst,
    input  logic                       sw_rst,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       write_enable,
    input  logic [$clog2(DEPTH)-1:0]   afull_value,
    input  logic                       read_enable,
    output logic [DATA_W-1:0]          rdata,
    output logic                       rdempty,
    output logic                       underflow,
    output logic                       wfull,
    output logic                       wr_almost_ful,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     fifo_write_count,
    output logic [$clog2(DEPTH):0]     wr_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [AW:0]       wptr_reg, rptr_reg, count_reg;
    logic              overflow_reg, underflow_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [DATA_W-1:0] mem [DEPTH];

    logic full, empty, wr_acc, rd_acc;

    // Acceptance is decided purely on pre-edge count, so a full FIFO drops a
    // write even when a read frees a slot in the same cycle (and vice versa).
    assign full   = (count_reg == DEPTH_CNT);
    assign empty  = (count_reg == '0);
    assign wr_acc = write_enable && !full  && !sw_rst && hw_rst;
    assign rd_acc = read_enable  && !empty && !sw_rst && hw_rst;

    always_ff @(posedge wclk or negedge hw_rst) begin
        if (!hw_rst) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            rdata_reg     <= '0;
        end else if (sw_rst) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc)
                wptr_reg <= wptr_reg + 1'b1;
            if (rd_acc) begin
                rptr_reg  <= rptr_reg + 1'b1;
                rdata_reg <= mem[rptr_reg[AW-1:0]];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            overflow_reg  <= write_enable && full;
            underflow_reg <= read_enable && empty;
        end
    end

    // Storage is outside the hw_rst domain; mem_rst wipes it and wins over a write.
    always_ff @(posedge wclk) begin
        if (!mem_rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_acc) begin
            mem[wptr_reg[AW-1:0]] <= wdata;
        end
    end

    assign rdata            = rdata_reg;
    assign rdempty          = empty;
    assign wfull            = full;
    assign overflow         = overflow_reg;
    assign underflow        = underflow_reg;
    assign fifo_write_count = count_reg;
    assign wr_level         = DEPTH_CNT - count_reg;
    assign wr_almost_ful    = (count_reg >= {1'b0, afull_value});
endmodule

// File: tb/tb_fifo_modport.sv
// Directed bench for fifo_modport: a vector table for basic traffic plus
// hand-written fill/drain, wrap, soft-reset, storage-clear and hard-reset sequences.
module tb_fifo_modport;
    logic        wclk = 1'b0;
    logic        hw_rst, mem_rst, sw_rst;
    logic [31:0] wdata;
    logic        write_enable, read_enable;
    logic [4:0]  afull_value;
    logic [31:0] rdata;
    logic        rdempty, underflow, wfull, wr_almost_ful, overflow;
    logic [5:0]  fifo_write_count, wr_level;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_modport #(.DATA_W(32), .DEPTH(32)) dut (
        .wclk(wclk), .hw_rst(hw_rst), .mem_rst(mem_rst), .sw_rst(sw_rst),
        .wdata(wdata), .write_enable(write_enable), .afull_value(afull_value),
        .read_enable(read_enable), .rdata(rdata), .rdempty(rdempty),
        .underflow(underflow), .wfull(wfull), .wr_almost_ful(wr_almost_ful),
        .overflow(overflow), .fifo_write_count(fifo_write_count), .wr_level(wr_level)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic        we;
        logic [31:0] wd;
        logic        re;
        logic [5:0]  cnt;
        logic        chk_rd;
        logic [31:0] rd;
        logic        ovf;
        logic        unf;
        logic        afull;
        logic        empty;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs launched on the falling edge; outputs observed 1 time unit after the rising edge.
    task automatic tick(input logic we, input logic [31:0] wd, input logic re,
                        input logic sr = 1'b0, input logic mr = 1'b1);
        @(negedge wclk);
        write_enable = we;
        wdata        = wd;
        read_enable  = re;
        sw_rst       = sr;
        mem_rst      = mr;
        @(posedge wclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 32'hA0, 1'b0, 6'd1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 32'hA1, 1'b0, 6'd2, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 32'hA2, 1'b0, 6'd3, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,  1'b1, 6'd2, 1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 32'hA3, 1'b1, 6'd2, 1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 32'h0,  1'b1, 6'd1, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 32'h0,  1'b1, 6'd0, 1'b1, 32'hA3, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 32'h0,  1'b1, 6'd0, 1'b1, 32'hA3, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 32'hA4, 1'b1, 6'd1, 1'b1, 32'hA3, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,  1'b0, 6'd1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 32'h0,  1'b1, 6'd0, 1'b1, 32'hA4, 1'b0, 1'b0, 1'b0, 1'b1};

        hw_rst = 1'b1; mem_rst = 1'b1; sw_rst = 1'b0;
        write_enable = 1'b0; read_enable = 1'b0; wdata = '0; afull_value = 5'd28;

        // Asynchronous reset, asserted between clock edges.
        #2 hw_rst = 1'b0;
        #1;
        chk("rst_count",   32'(fifo_write_count), 32'd0);
        chk("rst_level",   32'(wr_level), 32'd32);
        chk("rst_empty",   32'(rdempty), 32'd1);
        chk("rst_full",    32'(wfull), 32'd0);
        chk("rst_ovf",     32'(overflow), 32'd0);
        chk("rst_unf",     32'(underflow), 32'd0);
        chk("rst_rdata",   rdata, 32'd0);
        chk("rst_afull",   32'(wr_almost_ful), 32'd0);
        mem_rst = 1'b0;
        @(posedge wclk);
        @(posedge wclk);
        @(negedge wclk);
        mem_rst = 1'b1;
        hw_rst  = 1'b1;

        // Table-driven basic traffic, almost-full threshold 3.
        afull_value = 5'd3;
        for (int v = 0; v < 11; v++) begin
            tick(tbl[v].we, tbl[v].wd, tbl[v].re);
            $display("vec %0d we=%0b wd=%h re=%0b -> count=%0d rdata=%h ovf=%0b unf=%0b",
                     v, tbl[v].we, tbl[v].wd, tbl[v].re, fifo_write_count, rdata, overflow, underflow);
            chk($sformatf("vec%0d_count", v), 32'(fifo_write_count), 32'(tbl[v].cnt));
            chk($sformatf("vec%0d_ovf", v),   32'(overflow), 32'(tbl[v].ovf));
            chk($sformatf("vec%0d_unf", v),   32'(underflow), 32'(tbl[v].unf));
            chk($sformatf("vec%0d_afull", v), 32'(wr_almost_ful), 32'(tbl[v].afull));
            chk($sformatf("vec%0d_empty", v), 32'(rdempty), 32'(tbl[v].empty));
            if (tbl[v].chk_rd)
                chk($sformatf("vec%0d_rdata", v), rdata, tbl[v].rd);
        end

        // Fill to full with threshold 28.
        afull_value = 5'd28;
        for (int i = 0; i < 32; i++) begin
            tick(1'b1, 32'(i), 1'b0);
            chk($sformatf("fill%0d_count", i), 32'(fifo_write_count), 32'(i + 1));
            chk($sformatf("fill%0d_afull", i), 32'(wr_almost_ful), (i + 1 >= 28) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d_full", i),  32'(wfull), (i == 31) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d_level", i), 32'(wr_level), 32'(31 - i));
        end
        tick(1'b1, 32'h99, 1'b0);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(fifo_write_count), 32'd32);
        tick(1'b0, 32'h0, 1'b0);
        chk("ovf_clear", 32'(overflow), 32'd0);
        chk("ovf_count2", 32'(fifo_write_count), 32'd32);

        // Read and write together while full: read wins, write dropped.
        tick(1'b1, 32'h77, 1'b1);
        chk("fullrw_count", 32'(fifo_write_count), 32'd31);
        chk("fullrw_ovf",   32'(overflow), 32'd1);
        chk("fullrw_rdata", rdata, 32'h0);
        for (int i = 1; i < 32; i++) begin
            tick(1'b0, 32'h0, 1'b1);
            chk($sformatf("drain%0d_rdata", i), rdata, 32'(i));
            chk($sformatf("drain%0d_count", i), 32'(fifo_write_count), 32'(31 - i));
        end
        chk("drain_empty", 32'(rdempty), 32'd1);
        tick(1'b0, 32'h0, 1'b1);
        chk("unf_pulse", 32'(underflow), 32'd1);
        chk("unf_count", 32'(fifo_write_count), 32'd0);
        chk("unf_rdata_hold", rdata, 32'h1F);
        tick(1'b0, 32'h0, 1'b0);
        chk("unf_clear", 32'(underflow), 32'd0);

        // Simultaneous read/write at count 10 keeps count and order.
        for (int i = 0; i < 10; i++)
            tick(1'b1, 32'h100 + 32'(i), 1'b0);
        chk("mid_count", 32'(fifo_write_count), 32'd10);
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 32'h200 + 32'(k), 1'b1);
            chk($sformatf("midrw%0d_count", k), 32'(fifo_write_count), 32'd10);
            chk($sformatf("midrw%0d_rdata", k), rdata, 32'h100 + 32'(k));
        end
        for (int j = 0; j < 10; j++) begin
            tick(1'b0, 32'h0, 1'b1);
            chk($sformatf("middrain%0d_rdata", j), rdata,
                (j < 5) ? 32'h105 + 32'(j) : 32'h200 + 32'(j - 5));
        end
        chk("middrain_empty", 32'(rdempty), 32'd1);

        // Soft reset at count 17 with a concurrent write.
        for (int i = 0; i < 17; i++)
            tick(1'b1, 32'h300 + 32'(i), 1'b0);
        chk("pre_sw_count", 32'(fifo_write_count), 32'd17);
        tick(1'b1, 32'hBAD, 1'b0, 1'b1);
        chk("sw_count", 32'(fifo_write_count), 32'd0);
        chk("sw_empty", 32'(rdempty), 32'd1);
        chk("sw_level", 32'(wr_level), 32'd32);
        tick(1'b1, 32'h400, 1'b0);
        chk("postsw_count", 32'(fifo_write_count), 32'd1);
        tick(1'b0, 32'h0, 1'b1);
        chk("postsw_rdata", rdata, 32'h400);
        chk("postsw_empty", 32'(rdempty), 32'd1);

        // Storage clear with a colliding write: the slot reads back as zero.
        tick(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
        chk("memrst_count", 32'(fifo_write_count), 32'd1);
        tick(1'b0, 32'h0, 1'b1);
        chk("memrst_rdata", rdata, 32'h0);
        for (int i = 0; i < 32; i++)
            tick(1'b1, 32'h500 + 32'(i), 1'b0);
        chk("wrap_full", 32'(wfull), 32'd1);
        for (int i = 0; i < 32; i++) begin
            tick(1'b0, 32'h0, 1'b1);
            chk($sformatf("wrap%0d_rdata", i), rdata, 32'h500 + 32'(i));
        end
        chk("wrap_empty", 32'(rdempty), 32'd1);

        // Hard reset mid-operation, asserted between edges.
        for (int i = 0; i < 3; i++)
            tick(1'b1, 32'h600 + 32'(i), 1'b0);
        chk("prehw_count", 32'(fifo_write_count), 32'd3);
        #2 hw_rst = 1'b0;
        #1;
        chk("hw_count", 32'(fifo_write_count), 32'd0);
        chk("hw_empty", 32'(rdempty), 32'd1);
        chk("hw_level", 32'(wr_level), 32'd32);
        chk("hw_rdata", rdata, 32'h0);
        @(negedge wclk);
        hw_rst = 1'b1;
        write_enable = 1'b0;
        tick(1'b0, 32'h0, 1'b0);
        chk("posthw_count", 32'(fifo_write_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_modport.md
# fifo_modport

Single-clock 32-entry × 32-bit synchronous FIFO. It implements the write-side signal set carried by the write interface (`wdata`, `write_enable`, `afull_value`, `sw_rst`, `wfull`, `wr_almost_ful`, `overflow`, `fifo_write_count`, `wr_level`). It also has a minimal read port so the bench can drain it. The block sits behind the write interface's driver and monitor modports: the driver launches stimulus on the falling edge of `wclk`, and the monitor samples on the rising edge.

## Interface

Parameters:
- DATA_W, 32, data width
- DEPTH, 32, number of entries (power of two; pointers are log2(DEPTH)+1 bits)

Ports:
- wclk  in  1  sole clock; all state updates on posedge
- hw_rst  in  1  asynchronous, active-low hardware reset of all state except storage
- mem_rst  in  1  active-low, synchronous clear of storage array to 0 (pointers/flags unaffected)
- sw_rst  in  1  active-high synchronous soft reset: pointers, count, flags to reset values
- wdata  in  32  write data
- write_enable  in  1  write request
- afull_value  in  5  almost-full threshold
- read_enable  in  1  read request
- rdata  out  32  registered read data
- rdempty  out  1  FIFO empty
- underflow  out  1  one-cycle pulse, read attempted while empty
- wfull  out  1  FIFO full (count == 32)
- wr_almost_ful  out  1  count >= afull_value
- overflow  out  1  one-cycle pulse, write attempted while full
- fifo_write_count  out  6  entries stored, 0..32
- wr_level  out  6  free slots, 32 − fifo_write_count

## Operation

- Storage: 32×32 array, 6-bit write/read pointers. Bit 5 is the wrap bit. The low 5 bits address the array.
- Write accepted when write_enable=1 and wfull=0 at the clock edge. The word is stored at wptr[4:0] and wptr increments.
- Read accepted when read_enable=1 and rdempty=0. rdata <= mem[rptr[4:0]] and rptr increments. rdata holds its value otherwise.
- fifo_write_count:
  - Increments on write-only.
  - Decrements on read-only.
  - Unchanged when both are accepted or neither is.
- Flags are decided on pre-edge state:
  - Full with read and write in the same cycle: the read is accepted, the write is dropped, and overflow pulses.
  - Empty with read and write in the same cycle: the write is accepted, the read is rejected, and underflow pulses.
- wfull = (count == 32), rdempty = (count == 0), wr_level = 32 − count. All are derived from registered state with no combinational path from inputs.
- wr_almost_ful = (count >= afull_value), unsigned compare with afull_value zero-extended. afull_value = 0 forces wr_almost_ful = 1. afull_value may change at any time and takes effect immediately.
- overflow and underflow are registered, high for exactly the cycle after the offending edge, and not sticky.
- Reset priority: hw_rst (async) > sw_rst > normal operation.
  - sw_rst=1 ignores write_enable and read_enable in that cycle.
  - mem_rst=0 clears every array word in one cycle. It may coincide with other operations; a write in the same cycle is lost.

## Timing

- Reset values: fifo_write_count=0, wr_level=32, wfull=0, rdempty=1, overflow=0, underflow=0, rdata=0, pointers=0.
- wr_almost_ful at reset = (0 >= afull_value).
- hw_rst assertion clears state immediately, with no clock needed. Release is synchronous to the next posedge wclk.
- Write latency: the flags and count reflect a write one cycle after the accepting edge.
- Read latency: rdata is valid one cycle after the accepting edge.
- Pointer wrap: after 32 writes wptr = 6'b100000, which gives full (equal low bits, differing wrap bit). Operation continues correctly across multiple wraps.
- Reset mid-operation (hw_rst or sw_rst): in-flight data is discarded and the count returns to 0. The array keeps its contents unless mem_rst is asserted.

## Test plan

- Reset: assert hw_rst=0 without a clock. Required: count=0, wr_level=32, rdempty=1, wfull=0, overflow=0, rdata=0.
- Fill: with afull_value=28, write 32 words 0x0..0x1F. Required:
  - wr_almost_ful rises when count reaches 28.
  - wfull=1 and wr_level=0 after the 32nd write.
  - A 33rd write gives overflow=1 for one cycle and count stays 32.
- Drain and order: read 32 times. Required: rdata = 0x0..0x1F in order, rdempty=1 at the end. A further read gives underflow=1 for one cycle.
- Simultaneous read/write:
  - At count=10: count stays 10 and data order is preserved.
  - At full: count becomes 31 and overflow pulses.
  - At empty: count becomes 1 and underflow pulses.
- sw_rst with count=17 and write_enable=1. Required: next cycle count=0, rdempty=1, wr_level=32, and the write is not stored.
- mem_rst=0 for one cycle, then 32 writes and 32 reads across the pointer wrap. Required: the array is zero before the writes, and the reads return the written data, confirming wrap correctness.
